// File: rtl/hilo_pkg.sv
// hilo_pkg
// Shared definitions for the HiLo multiply/divide sequencer:
//   - op_e      : operation codes presented on Op
//   - state_e   : sequencer states
//   - ITER_COUNT: number of iterative steps per multiply/divide
//   - LAST_ITER : counter value of the final iterative step
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MSUB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WRITE = 2'd2,
        ST_ABORT = 2'd3
    } state_e;

    localparam int ITER_COUNT = 32;
    localparam logic [4:0] LAST_ITER = 5'(ITER_COUNT - 1);

    // Divide ops share the restoring-subtract datapath and the divide-by-zero check.
    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Ops whose operands are two's complement and need magnitude/sign handling.
    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/hilo_iter_step.sv
// hilo_iter_step
// One combinational iteration of the unsigned multiply/divide engine.
//   is_div  in  1   0: shift-add multiply step, 1: restoring-divide step
//   acc_in  in  64  partial accumulator
//                   multiply: {partial product high, remaining multiplier bits}
//                   divide  : {partial remainder, dividend bits / quotient bits}
//   operand in  32  multiplicand (multiply) or divisor (divide), magnitude
//   acc_out out 64  accumulator after this step
// After 32 steps the accumulator holds {Hi, Lo} of the unsigned result:
// the 64-bit product, or {remainder, quotient}.
module hilo_iter_step (
    input  logic        is_div,
    input  logic [63:0] acc_in,
    input  logic [31:0] operand,
    output logic [63:0] acc_out
);

    logic [32:0] mul_sum;
    logic [32:0] trial;

    always_comb begin
        // Multiply: add multiplicand into the high half when the current
        // multiplier LSB is set, then shift the 65-bit {carry, acc} right.
        mul_sum = {1'b0, acc_in[63:32]} + (acc_in[0] ? {1'b0, operand} : 33'd0);

        // Divide: shift the next dividend bit into the remainder and try
        // subtracting. Bit 32 of the 33-bit difference set means "borrow".
        trial = {acc_in[63:32], acc_in[31]} - {1'b0, operand};

        if (is_div) begin
            if (!trial[32]) begin
                acc_out = {trial[31:0], acc_in[30:0], 1'b1};
            end else begin
                acc_out = {acc_in[62:0], 1'b0};
            end
        end else begin
            acc_out = {mul_sum, acc_in[31:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
// Multi-cycle multiply/divide sequencer owning the HiLo write port.
// Ports:
//   Clk, Reset           clock, synchronous active-high reset
//   Start, Op            operation request and code (hilo_pkg::op_e)
//   OperandA, OperandB   rs / rt values
//   HiLoIn               current {Hi, Lo}
//   Busy                 sequencer not idle
//   Stall                Start while Busy (combinational)
//   HiLoWriteEnable      one-cycle HiLo write strobe
//   HiLoWriteData        registered {Hi, Lo} write value, held between writes
//   Done                 one-cycle completion pulse
//   DivByZero            one-cycle pulse for DIV/DIVU with OperandB == 0
// Configuration macro: HILO_MADD_EN enables MADD/MSUB (codes 6/7); when
// undefined those codes are ignored and the HiLo accumulate adder is absent.
module hilo_muldiv_ctrl
    import hilo_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] OperandA,
    input  logic [31:0] OperandB,
    input  logic [63:0] HiLoIn,
    output logic        Busy,
    output logic        Stall,
    output logic        HiLoWriteEnable,
    output logic [63:0] HiLoWriteData,
    output logic        Done,
    output logic        DivByZero
);

    state_e      state_reg;
    logic [4:0]  count_reg;
    logic [63:0] acc_reg;
    logic [31:0] operand_reg;
    op_e         op_reg;
    logic        neg_res_reg;
    logic        neg_rem_reg;
    logic [63:0] wdata_reg;
    logic        busy_reg;
    logic        we_reg;
    logic        done_reg;
    logic        dbz_reg;

    op_e         op_in;
    logic        op_valid;
    logic        req_signed;
    logic        req_div;
    logic        can_accept;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] mt_data;
    logic        run_is_div;
    logic [63:0] step_out;
    logic [63:0] fix_prod;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;
    logic [63:0] result_next;

    // Request decode and operand magnitudes, evaluated on the accept edge.
    always_comb begin
        op_in = op_e'(Op);
`ifdef HILO_MADD_EN
        op_valid = 1'b1;
`else
        op_valid = (op_in != OP_MADD) && (op_in != OP_MSUB);
`endif
        req_signed = op_is_signed(op_in);
        req_div    = op_is_div(op_in);
        // A new request may land on the edge that leaves WRITE/ABORT.
        can_accept = (state_reg != ST_RUN);
        mag_a = (req_signed && OperandA[31]) ? (32'd0 - OperandA) : OperandA;
        mag_b = (req_signed && OperandB[31]) ? (32'd0 - OperandB) : OperandB;
        mt_data = (op_in == OP_MTHI) ? {OperandA, HiLoIn[31:0]} : {HiLoIn[63:32], OperandA};
    end

    assign run_is_div = op_is_div(op_reg);

    hilo_iter_step u_step (
        .is_div  (run_is_div),
        .acc_in  (acc_reg),
        .operand (operand_reg),
        .acc_out (step_out)
    );

    // Sign fix-up applied to the accumulator produced by the last step.
    // Quotient takes the XOR of operand signs, remainder the dividend sign.
    always_comb begin
        fix_prod = neg_res_reg ? (64'd0 - step_out) : step_out;
        fix_hi   = neg_rem_reg ? (32'd0 - step_out[63:32]) : step_out[63:32];
        fix_lo   = neg_res_reg ? (32'd0 - step_out[31:0]) : step_out[31:0];
        result_next = run_is_div ? {fix_hi, fix_lo} : fix_prod;
`ifdef HILO_MADD_EN
        if (op_reg == OP_MADD) begin
            result_next = HiLoIn + fix_prod;
        end else if (op_reg == OP_MSUB) begin
            result_next = HiLoIn - fix_prod;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= ST_IDLE;
            count_reg   <= 5'd0;
            acc_reg     <= 64'd0;
            operand_reg <= 32'd0;
            op_reg      <= OP_MULT;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            wdata_reg   <= 64'd0;
            busy_reg    <= 1'b0;
            we_reg      <= 1'b0;
            done_reg    <= 1'b0;
            dbz_reg     <= 1'b0;
        end else begin
            we_reg   <= 1'b0;
            done_reg <= 1'b0;
            dbz_reg  <= 1'b0;

            if (can_accept && Start && op_valid) begin
                busy_reg    <= 1'b1;
                count_reg   <= 5'd0;
                op_reg      <= op_in;
                neg_res_reg <= req_signed & (OperandA[31] ^ OperandB[31]);
                neg_rem_reg <= req_signed & OperandA[31];
                if ((op_in == OP_MTHI) || (op_in == OP_MTLO)) begin
                    state_reg <= ST_WRITE;
                    wdata_reg <= mt_data;
                    we_reg    <= 1'b1;
                    done_reg  <= 1'b1;
                end else if (req_div && (OperandB == 32'd0)) begin
                    state_reg <= ST_ABORT;
                    done_reg  <= 1'b1;
                    dbz_reg   <= 1'b1;
                end else begin
                    state_reg <= ST_RUN;
                    // Multiply iterates over the multiplier in the low half;
                    // divide shifts the dividend out of the low half.
                    acc_reg     <= {32'd0, req_div ? mag_a : mag_b};
                    operand_reg <= req_div ? mag_b : mag_a;
                end
            end else begin
                case (state_reg)
                    ST_RUN: begin
                        acc_reg <= step_out;
                        if (count_reg == LAST_ITER) begin
                            state_reg <= ST_WRITE;
                            wdata_reg <= result_next;
                            we_reg    <= 1'b1;
                            done_reg  <= 1'b1;
                        end else begin
                            count_reg <= count_reg + 5'd1;
                        end
                    end
                    ST_WRITE, ST_ABORT: begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign Busy            = busy_reg;
    assign Stall           = Start & busy_reg;
    assign HiLoWriteEnable = we_reg;
    assign HiLoWriteData   = wdata_reg;
    assign Done            = done_reg;
    assign DivByZero       = dbz_reg;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl
// Directed bench for hilo_muldiv_ctrl. A cycle-level reference model derives
// expected outputs from plain arithmetic and busy-cycle counts; a compare
// process checks every cycle, and directed cases pin literal results.
module tb_hilo_muldiv_ctrl;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic [63:0] HiLoIn;
    logic        Busy;
    logic        Stall;
    logic        HiLoWriteEnable;
    logic [63:0] HiLoWriteData;
    logic        Done;
    logic        DivByZero;

    hilo_muldiv_ctrl dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Start           (Start),
        .Op              (Op),
        .OperandA        (OperandA),
        .OperandB        (OperandB),
        .HiLoIn          (HiLoIn),
        .Busy            (Busy),
        .Stall           (Stall),
        .HiLoWriteEnable (HiLoWriteEnable),
        .HiLoWriteData   (HiLoWriteData),
        .Done            (Done),
        .DivByZero       (DivByZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic model_valid(input logic [2:0] op);
`ifdef HILO_MADD_EN
        return (op <= 3'd7);
`else
        return (op < 3'd6);
`endif
    endfunction

    function automatic logic [63:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [63:0] hl);
        longint sp;
        int     q;
        int     r;
        logic [63:0] res;
        sp = longint'($signed(a)) * longint'($signed(b));
        res = 64'd0;
        case (op)
            3'd0: res = sp;
            3'd1: res = {32'd0, a} * {32'd0, b};
            3'd2: begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                res = {r, q};
            end
            3'd3: res = {a % b, a / b};
            3'd4: res = {a, hl[31:0]};
            3'd5: res = {hl[63:32], a};
            3'd6: res = hl + sp;
            default: res = hl - sp;
        endcase
        return res;
    endfunction

    // m_remain: busy cycles still to go including the current one.
    int          m_remain = 0;
    logic        m_is_write = 1'b0;
    logic [63:0] m_result = 64'd0;
    logic [63:0] m_data = 64'd0;

    always @(posedge Clk) begin
        if (Reset) begin
            m_remain   = 0;
            m_is_write = 1'b0;
            m_data     = 64'd0;
        end else begin
            if (m_remain <= 1 && Start && model_valid(Op)) begin
                if ((Op == 3'd2 || Op == 3'd3) && OperandB == 32'd0) begin
                    m_remain   = 1;
                    m_is_write = 1'b0;
                end else begin
                    m_is_write = 1'b1;
                    m_result   = model_result(Op, OperandA, OperandB, HiLoIn);
                    m_remain   = (Op == 3'd4 || Op == 3'd5) ? 1 : 33;
                end
            end else if (m_remain > 0) begin
                m_remain--;
            end
            if (m_remain == 1 && m_is_write) m_data = m_result;
        end
    end

    // ---------------- per-cycle compare + bookkeeping ----------------
    int          we_count = 0;
    int          dbz_count = 0;
    int          busy_len = 0;
    int          last_busy_len = 0;
    logic [63:0] last_wdata = 64'd0;

    always @(posedge Clk) begin
        #1;
        check("busy",  {63'd0, Busy},            {63'd0, m_remain > 0});
        check("we",    {63'd0, HiLoWriteEnable}, {63'd0, m_remain == 1 && m_is_write});
        check("done",  {63'd0, Done},            {63'd0, m_remain == 1});
        check("dbz",   {63'd0, DivByZero},       {63'd0, m_remain == 1 && !m_is_write});
        check("stall", {63'd0, Stall},           {63'd0, Start && m_remain > 0});
        check("wdata", HiLoWriteData, m_data);
        if (HiLoWriteEnable === 1'b1) begin
            we_count++;
            last_wdata = HiLoWriteData;
        end
        if (DivByZero === 1'b1) dbz_count++;
        if (Busy === 1'b1) begin
            busy_len++;
        end else if (busy_len > 0) begin
            last_busy_len = busy_len;
            busy_len = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] hl);
        @(negedge Clk);
        Start = 1'b1; Op = op; OperandA = a; OperandB = b; HiLoIn = hl;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            if (Busy === 1'b0) return;
            @(negedge Clk);
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: Busy still high after 200 cycles, required low", name);
    endtask

    task automatic wait_we(input string name);
        for (int i = 0; i < 200; i++) begin
            if (HiLoWriteEnable === 1'b1) return;
            @(negedge Clk);
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: no HiLoWriteEnable within 200 cycles, required one", name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    localparam int NTAB = 6;
    logic [2:0]  tab_op [NTAB] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd3, 3'd1};
    logic [31:0] tab_a  [NTAB] = '{32'h80000000, 32'h7FFFFFFF, 32'd7, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h12345678};
    logic [31:0] tab_b  [NTAB] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd3, 32'h9ABCDEF0};

    initial begin
        int we0;
        int dbz0;
        Reset = 1'b1; Start = 1'b0; Op = 3'd0;
        OperandA = 32'd0; OperandB = 32'd0; HiLoIn = 64'd0;
        repeat (3) @(negedge Clk);
        check("reset_busy",  {63'd0, Busy}, 64'd0);
        check("reset_wdata", HiLoWriteData, 64'd0);
        Reset = 1'b0;

        // MULT -3 * 7
        we0 = we_count;
        start_op(3'd0, 32'hFFFFFFFD, 32'd7, 64'd0);
        wait_idle("mult_idle");
        check("mult_data", last_wdata, 64'hFFFFFFFF_FFFFFFEB);
        check("mult_we_count", 64'(we_count - we0), 64'd1);
        check("mult_busy_len", 64'(last_busy_len), 64'd33);
        $display("MULT  -3*7        data=%h busy=%0d", last_wdata, last_busy_len);

        // MULTU max*max, then back-to-back MULT 3*5 on the WRITE-exit edge
        start_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0);
        wait_we("multu_we");
        check("multu_data", HiLoWriteData, 64'hFFFFFFFE_00000001);
        Start = 1'b1; Op = 3'd0; OperandA = 32'd3; OperandB = 32'd5;
        @(negedge Clk);
        Start = 1'b0;
        check("b2b_busy", {63'd0, Busy}, 64'd1);
        wait_idle("b2b_idle");
        check("b2b_data", last_wdata, 64'd15);
        check("b2b_busy_len", 64'(last_busy_len), 64'd66);
        $display("MULTU max*max + MULT 3*5 back-to-back data=%h busy=%0d", last_wdata, last_busy_len);

        // DIV -7 / 2
        start_op(3'd2, 32'hFFFFFFF9, 32'd2, 64'd0);
        wait_idle("div_idle");
        check("div_data", last_wdata, 64'hFFFFFFFF_FFFFFFFD);
        $display("DIV   -7/2        data=%h", last_wdata);

        // DIVU by zero
        we0 = we_count; dbz0 = dbz_count;
        start_op(3'd3, 32'd7, 32'd0, 64'd0);
        wait_idle("dbz_idle");
        check("dbz_no_we", 64'(we_count - we0), 64'd0);
        check("dbz_pulse", 64'(dbz_count - dbz0), 64'd1);
        check("dbz_busy_len", 64'(last_busy_len), 64'd1);
        check("dbz_data_held", HiLoWriteData, 64'hFFFFFFFF_FFFFFFFD);
        $display("DIVU  7/0         dbz=%0d we=%0d", dbz_count - dbz0, we_count - we0);

        // MTHI / MTLO
        start_op(3'd4, 32'hAAAA5555, 32'd0, 64'h11111111_22222222);
        wait_idle("mthi_idle");
        check("mthi_data", last_wdata, 64'hAAAA5555_22222222);
        check("mthi_busy_len", 64'(last_busy_len), 64'd1);
        $display("MTHI              data=%h", last_wdata);
        start_op(3'd5, 32'hAAAA5555, 32'd0, 64'h11111111_22222222);
        wait_idle("mtlo_idle");
        check("mtlo_data", last_wdata, 64'h11111111_AAAA5555);
        $display("MTLO              data=%h", last_wdata);

        // Start while busy is stalled and ignored
        we0 = we_count;
        start_op(3'd0, 32'h12345678, 32'd9, 64'd0);
        repeat (4) @(negedge Clk);
        Start = 1'b1; Op = 3'd1; OperandA = 32'd1; OperandB = 32'd1;
        #1;
        check("stall_mid", {63'd0, Stall}, 64'd1);
        @(negedge Clk);
        Start = 1'b0;
        wait_idle("stall_idle");
        check("stall_we_count", 64'(we_count - we0), 64'd1);
        check("stall_busy_len", 64'(last_busy_len), 64'd33);
        check("stall_data", last_wdata, 64'h00000000_A3D70A38);
        $display("MULT  with stalled Start data=%h busy=%0d", last_wdata, last_busy_len);

        // Reset mid-operation
        we0 = we_count;
        start_op(3'd0, 32'd100, 32'd200, 64'd0);
        repeat (9) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("rst_busy",  {63'd0, Busy}, 64'd0);
        check("rst_done",  {63'd0, Done}, 64'd0);
        check("rst_wdata", HiLoWriteData, 64'd0);
        repeat (40) @(negedge Clk);
        check("rst_no_we", 64'(we_count - we0), 64'd0);
        $display("RESET mid-MULT    busy=%0d we=%0d", Busy, we_count - we0);

        // Op 6: MADD when enabled, otherwise reserved
`ifdef HILO_MADD_EN
        start_op(3'd6, 32'd4, 32'hFFFFFFFF, 64'h00000000_00000010);
        wait_idle("madd_idle");
        check("madd_data", last_wdata, 64'h00000000_0000000C);
        $display("MADD  0x10+4*-1   data=%h", last_wdata);
        start_op(3'd7, 32'd4, 32'hFFFFFFFF, 64'h00000000_00000010);
        wait_idle("msub_idle");
        check("msub_data", last_wdata, 64'h00000000_00000014);
        $display("MSUB  0x10-4*-1   data=%h", last_wdata);
`else
        we0 = we_count;
        start_op(3'd6, 32'd4, 32'hFFFFFFFF, 64'h00000000_00000010);
        check("op6_busy", {63'd0, Busy}, 64'd0);
        repeat (3) @(negedge Clk);
        check("op6_no_we", 64'(we_count - we0), 64'd0);
        $display("OP6   reserved    busy=%0d we=%0d", Busy, we_count - we0);
`endif

        // Additional vectors checked by the per-cycle model
        for (int i = 0; i < NTAB; i++) begin
            start_op(tab_op[i], tab_a[i], tab_b[i], 64'd0);
            wait_idle("tab_idle");
            $display("TAB   op=%0d a=%h b=%h data=%h", tab_op[i], tab_a[i], tab_b[i], last_wdata);
        end

        repeat (2) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
